// File: rtl/sam_enc_param.sv
// Parametrised serial SAM encoder.
// Configuration (length, key d, key N) arrives serially on str while mode is high.
// In normal operation, pulse-width-coded symbols are decoded into bits.
// Each bit is encoded as (b ^ d[i]) | N[i] and the word is assembled MSB first.
// Completed words are published on msgcd, together with a one-cycle valid pulse.
module sam_enc_param #(
  parameter int MSG_W   = 64,
  parameter int LW      = 6,
  parameter int CNT_W   = 7,
  parameter int MIN_SYM = 10,
  parameter int MAX_SYM = 60
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     str,
  input  logic                     mode,
  output logic [MSG_W-1:0]         msgcd,
  output logic                     valid,
  output logic [$clog2(MSG_W):0]   cc,
  output logic                     sym_err,
  output logic                     cfg_err,
  output logic                     busy
);
  localparam int IW  = $clog2(MSG_W);
  localparam int CCW = $clog2(MSG_W) + 1;

  localparam logic [LW:0]      LEN_ONE     = (LW+1)'(1);
  localparam logic [LW:0]      LEN_MAX     = (LW+1)'(MSG_W);
  localparam logic [LW:0]      LEN_BITS_M1 = (LW+1)'(LW-1);
  localparam logic [CNT_W-1:0] SAT         = CNT_W'(MAX_SYM+1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   MIN_T       = (CNT_W+1)'(MIN_SYM);
  localparam logic [CNT_W:0]   MAX_T       = (CNT_W+1)'(MAX_SYM);
  localparam logic [IW-1:0]    IDX_ONE     = IW'(1);

  typedef enum logic [2:0] {IDLE, CFG_LEN, CFG_D, CFG_N, CFG_WAIT, NORM} state_t;
  state_t state_reg, state_next;

  logic [LW-2:0]    field_reg;
  logic [LW:0]      len_reg;
  logic [LW:0]      cnt_reg;
  logic [MSG_W-1:0] d_reg, n_reg, word_reg, msgcd_reg;
  logic [IW-1:0]    idx_reg;
  logic [CNT_W-1:0] ones_reg, zeros_reg;
  logic             zero_seen_reg, broken_reg, sync_reg, prev_reg;
  logic             valid_reg, sym_err_reg, cfg_err_reg, busy_reg;
  logic [CCW-1:0]   cc_reg;

  logic             rise;
  logic [LW-1:0]    field_full;
  logic [LW:0]      len_new, len_m1;
  logic             len_ok, len_last, cfg_last;
  logic [CNT_W-1:0] ones_inc, zeros_inc;
  logic [CNT_W:0]   sym_len;
  logic             sym_bad, enc_bit;
  logic [MSG_W-1:0] word_set, len_mask;

  // Bits at or above the configured length are forced to zero when a word is published.
  for (genvar gi = 0; gi < MSG_W; gi++) begin : g_mask
    assign len_mask[gi] = (int'(len_reg) > gi);
  end

  // Shared decode helpers: edge detection, length field, counters and the encoded bit.
  always_comb begin
    rise       = str & ~prev_reg;
    field_full = {field_reg, str};
    len_new    = {1'b0, field_full} + LEN_ONE;
    len_ok     = (len_new <= LEN_MAX);
    len_last   = (cnt_reg == LEN_BITS_M1);
    len_m1     = len_reg - LEN_ONE;
    cfg_last   = (cnt_reg == len_m1);
    ones_inc   = (ones_reg == SAT) ? SAT : ones_reg + CNT_ONE;
    zeros_inc  = (zeros_reg == SAT) ? SAT : zeros_reg + CNT_ONE;
    sym_len    = {1'b0, ones_reg} + {1'b0, zeros_reg};
    sym_bad    = broken_reg | (sym_len < MIN_T) | (sym_len > MAX_T);
    enc_bit    = ((ones_reg >= zeros_reg) ^ d_reg[idx_reg]) | n_reg[idx_reg];
    word_set   = word_reg;
    word_set[idx_reg] = enc_bit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; dropping mode during configuration aborts back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (mode) state_next = CFG_LEN;
      CFG_LEN:  if (!mode) state_next = IDLE;
                else if (len_last) state_next = len_ok ? CFG_D : IDLE;
      CFG_D:    if (!mode) state_next = IDLE;
                else if (cfg_last) state_next = CFG_N;
      CFG_N:    if (!mode) state_next = IDLE;
                else if (cfg_last) state_next = CFG_WAIT;
      CFG_WAIT: if (!mode) state_next = NORM;
      NORM:     if (mode) state_next = CFG_LEN;
      default:  state_next = IDLE;
    endcase
  end

  // Datapath: config shifting, symbol measurement, word assembly and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      field_reg <= '0; len_reg <= '0; cnt_reg <= '0;
      d_reg <= '0; n_reg <= '0; word_reg <= '0; msgcd_reg <= '0;
      idx_reg <= '0; ones_reg <= '0; zeros_reg <= '0;
      zero_seen_reg <= 1'b0; broken_reg <= 1'b0; sync_reg <= 1'b0; prev_reg <= 1'b0;
      valid_reg <= 1'b0; sym_err_reg <= 1'b0; cfg_err_reg <= 1'b0; busy_reg <= 1'b0;
      cc_reg <= '0;
    end else begin
      prev_reg    <= str;
      valid_reg   <= 1'b0;
      sym_err_reg <= 1'b0;
      cfg_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          d_reg <= '0; n_reg <= '0; field_reg <= '0; cnt_reg <= '0; len_reg <= '0;
        end
        CFG_LEN: begin
          if (!mode) begin
            cfg_err_reg <= 1'b1; cc_reg <= '0;
          end else begin
            field_reg <= field_full[LW-2:0];
            cnt_reg   <= cnt_reg + LEN_ONE;
            if (len_last) begin
              cnt_reg <= '0;
              len_reg <= len_new;
              if (!len_ok) begin
                cfg_err_reg <= 1'b1; cc_reg <= '0;
              end
            end
          end
        end
        CFG_D: begin
          if (!mode) begin
            cfg_err_reg <= 1'b1; cc_reg <= '0;
          end else begin
            // First bit received ends up at d[L-1] after L shifts.
            d_reg   <= {d_reg[MSG_W-2:0], str};
            cnt_reg <= cfg_last ? '0 : cnt_reg + LEN_ONE;
          end
        end
        CFG_N: begin
          if (!mode) begin
            cfg_err_reg <= 1'b1; cc_reg <= '0;
          end else begin
            n_reg   <= {n_reg[MSG_W-2:0], str};
            cnt_reg <= cfg_last ? '0 : cnt_reg + LEN_ONE;
            if (cfg_last) cc_reg <= CCW'(len_reg);
          end
        end
        CFG_WAIT: begin
          if (!mode) begin
            idx_reg <= IW'(len_m1); word_reg <= '0;
            ones_reg <= '0; zeros_reg <= '0; sync_reg <= 1'b0;
            zero_seen_reg <= 1'b0; broken_reg <= 1'b0; busy_reg <= 1'b0;
          end
        end
        NORM: begin
          if (mode) begin
            // Reconfiguration request: drop the partial word, keep msgcd and cc.
            busy_reg <= 1'b0; word_reg <= '0; sync_reg <= 1'b0;
            d_reg <= '0; n_reg <= '0; field_reg <= '0; cnt_reg <= '0;
          end else if (!sync_reg) begin
            if (rise) begin
              sync_reg <= 1'b1; ones_reg <= CNT_ONE; zeros_reg <= '0;
              zero_seen_reg <= 1'b0; broken_reg <= 1'b0;
            end
          end else if (rise) begin
            if (sym_bad) begin
              sym_err_reg <= 1'b1;
            end else if (idx_reg == '0) begin
              msgcd_reg <= word_set & len_mask;
              valid_reg <= 1'b1;
              idx_reg   <= IW'(len_m1);
              busy_reg  <= 1'b0;
              word_reg  <= '0;
            end else begin
              word_reg <= word_set;
              idx_reg  <= idx_reg - IDX_ONE;
              busy_reg <= 1'b1;
            end
            ones_reg <= CNT_ONE; zeros_reg <= '0;
            zero_seen_reg <= 1'b0; broken_reg <= 1'b0;
          end else if (str) begin
            if (!zero_seen_reg) begin
              ones_reg <= ones_inc;
              if (ones_inc == SAT) broken_reg <= 1'b1;
            end
          end else begin
            zeros_reg     <= zeros_inc;
            zero_seen_reg <= 1'b1;
            if (zeros_inc == SAT) broken_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    msgcd   = msgcd_reg;
    valid   = valid_reg;
    cc      = cc_reg;
    sym_err = sym_err_reg;
    cfg_err = cfg_err_reg;
    busy    = busy_reg;
  end
endmodule

// File: tb/tb_sam_enc_param.sv
// Bench for sam_enc_param.
// Directed scenarios are followed by randomized words.
// The expected values come from a symbol-level reference model.
module tb_sam_enc_param;
  localparam int LW = 6, MIN = 10, MAX = 60;

  logic clk = 1'b0;
  logic reset, str, mode, str16, mode16;
  logic [63:0] msgcd;
  logic        valid, sym_err, cfg_err, busy;
  logic [6:0]  cc;
  logic [15:0] msgcd16;
  logic        valid16, sym_err16, cfg_err16, busy16;
  logic [4:0]  cc16;

  always #5 clk = ~clk;

  sam_enc_param dut (
    .clk(clk), .reset(reset), .str(str), .mode(mode), .msgcd(msgcd), .valid(valid),
    .cc(cc), .sym_err(sym_err), .cfg_err(cfg_err), .busy(busy));

  sam_enc_param #(.MSG_W(16)) dut16 (
    .clk(clk), .reset(reset), .str(str16), .mode(mode16), .msgcd(msgcd16), .valid(valid16),
    .cc(cc16), .sym_err(sym_err16), .cfg_err(cfg_err16), .busy(busy16));

  int total = 0, bad = 0;
  int sym_cnt = 0, exp_sym = 0, viol = 0;
  logic pv = 1'b0, ps = 1'b0, pc = 1'b0;
  logic [63:0] got_q[$], exp_q[$];
  int mL = 0, midx = 0;
  logic [63:0] md = '0, mn = '0, mword = '0;
  logic armed = 1'b0, pending = 1'b0;
  int pend_o = 0, pend_z = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, then sample just after the edge.
  task automatic tick(input logic s, input logic m);
    str = s; mode = m;
    @(posedge clk); #1;
    if (valid) got_q.push_back(msgcd);
    if (sym_err) sym_cnt++;
    if ((valid && pv) || (sym_err && ps) || (cfg_err && pc)) viol++;
    pv = valid; ps = sym_err; pc = cfg_err;
  endtask

  // Reference: a closed symbol (o ones, z zeros) either is rejected or yields one encoded bit.
  task automatic model_sym(input int o, input int z);
    logic b, e;
    if (!armed) return;
    if (o > MAX || z > MAX || (o + z) < MIN || (o + z) > MAX) begin
      exp_sym++;
    end else begin
      b = (o >= z);
      e = (b ^ md[midx]) | mn[midx];
      mword[midx] = e;
      if (midx == 0) begin
        exp_q.push_back(mword); mword = '0; midx = mL - 1;
      end else begin
        midx--;
      end
    end
  endtask

  task automatic send_sym(input int o, input int z);
    tick(1'b1, 1'b0);
    if (pending) model_sym(pend_o, pend_z);
    for (int k = 1; k < o; k++) tick(1'b1, 1'b0);
    for (int k = 0; k < z; k++) tick(1'b0, 1'b0);
    pend_o = o; pend_z = z; pending = armed;
  endtask

  task automatic close_sym();
    tick(1'b1, 1'b0);
    if (pending) model_sym(pend_o, pend_z);
    pending = 1'b0;
  endtask

  task automatic do_cfg(input int L, input logic [63:0] d, input logic [63:0] n);
    tick(1'b0, 1'b1);
    for (int k = LW - 1; k >= 0; k--) tick(1'((L - 1) >> k), 1'b1);
    for (int k = L - 1; k >= 0; k--) tick(d[k], 1'b1);
    for (int k = L - 1; k >= 0; k--) tick(n[k], 1'b1);
    chk($sformatf("cfg_cc_L%0d", L), 64'(cc), 64'(L));
    tick(1'b0, 1'b0);
    mL = L; md = d; mn = n; mword = '0; midx = L - 1;
    armed = 1'b1; pending = 1'b0;
    sym_cnt = 0; exp_sym = 0;
  endtask

  task automatic check_words(input string tag);
    chk($sformatf("%s_nwords", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    logic [63:0] mask, rd, rn;
    int L, nsym, o, z;
    reset = 1'b1; str = 1'b0; mode = 1'b0; str16 = 1'b0; mode16 = 1'b0;
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    chk("rst_msgcd", msgcd, 64'h0);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_cc", 64'(cc), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_errs", 64'({sym_err, cfg_err}), 64'h0);
    chk("rst_cc16", 64'(cc16), 64'h0);
    reset = 1'b0;
    tick(1'b0, 1'b0);

    // Oversized length on the 16-bit instance, then a legal maximum-length config.
    mode16 = 1'b1; tick(1'b0, 1'b0);
    for (int k = 5; k >= 0; k--) begin str16 = 1'(20 >> k); tick(1'b0, 1'b0); end
    chk("t5_cfg_err", 64'(cfg_err16), 64'h1);
    chk("t5_cc16", 64'(cc16), 64'h0);
    mode16 = 1'b0; str16 = 1'b0; tick(1'b0, 1'b0);
    chk("t5_cfg_err_once", 64'(cfg_err16), 64'h0);
    mode16 = 1'b1; tick(1'b0, 1'b0);
    for (int k = 5; k >= 0; k--) begin str16 = 1'(15 >> k); tick(1'b0, 1'b0); end
    for (int k = 0; k < 32; k++) begin str16 = 1'(k); tick(1'b0, 1'b0); end
    chk("t5_cc16_max", 64'(cc16), 64'd16);
    mode16 = 1'b0; str16 = 1'b0; tick(1'b0, 1'b0);

    // Basic word: bits 1,0,1,1 with d=1010, N=0000.
    do_cfg(4, 64'hA, 64'h0);
    send_sym(8, 4); send_sym(4, 8); send_sym(8, 4); send_sym(8, 4);
    chk("t1_no_early_valid", 64'(got_q.size()), 64'h0);
    close_sym();
    chk("t1_valid_edge", 64'(valid), 64'h1);
    chk("t1_msgcd", msgcd, 64'h1);
    tick(1'b0, 1'b0);
    chk("t1_valid_one_cycle", 64'(valid), 64'h0);
    check_words("t1");

    // Two consecutive words with N=0100, no mode toggle between them.
    do_cfg(4, 64'hA, 64'h4);
    send_sym(8, 4); send_sym(4, 8); send_sym(8, 4); send_sym(8, 4);
    for (int k = 0; k < 4; k++) send_sym(4, 8);
    close_sym();
    chk("t2_last_msgcd", msgcd, 64'hE);
    check_words("t2");

    // Illegal symbols are discarded without consuming a bit position.
    do_cfg(4, 64'hA, 64'h0);
    send_sym(3, 3); send_sym(2, 70); send_sym(8, 4);
    chk("t3_sym_err_cnt", 64'(sym_cnt), 64'd2);
    chk("t3_busy_idle", 64'(busy), 64'h0);
    send_sym(4, 8);
    chk("t3_busy_after_bit", 64'(busy), 64'h1);
    send_sym(8, 4); send_sym(8, 4); close_sym();
    chk("t3_sym_model", 64'(sym_cnt), 64'(exp_sym));
    chk("t3_msgcd", msgcd, 64'h1);
    check_words("t3");

    // Abort configuration after two d bits.
    tick(1'b0, 1'b1);
    for (int k = 5; k >= 0; k--) tick(1'(3 >> k), 1'b1);
    tick(1'b1, 1'b1); tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("t4_cfg_err", 64'(cfg_err), 64'h1);
    chk("t4_cc", 64'(cc), 64'h0);
    tick(1'b0, 1'b0);
    chk("t4_cfg_err_once", 64'(cfg_err), 64'h0);
    armed = 1'b0; pending = 1'b0;
    send_sym(8, 4); send_sym(4, 8); send_sym(8, 4); send_sym(8, 4); close_sym();
    chk("t4_no_valid", 64'(got_q.size()), 64'h0);
    chk("t4_msgcd_held", msgcd, 64'h1);
    got_q.delete();

    // Reset in the middle of a word.
    do_cfg(4, 64'hA, 64'h4);
    send_sym(8, 4); send_sym(4, 8);
    chk("t6_busy_mid", 64'(busy), 64'h1);
    reset = 1'b1; tick(1'b0, 1'b0); reset = 1'b0;
    chk("t6_msgcd", msgcd, 64'h0);
    chk("t6_cc", 64'(cc), 64'h0);
    chk("t6_valid", 64'(valid), 64'h0);
    chk("t6_busy", 64'(busy), 64'h0);
    armed = 1'b0; pending = 1'b0;
    send_sym(8, 4); send_sym(4, 8); send_sym(8, 4); send_sym(8, 4); close_sym();
    chk("t6_ignored", 64'(got_q.size()), 64'h0);
    got_q.delete(); exp_q.delete();

    // Randomized configurations and symbol streams, including L=1 and L=64.
    for (int it = 0; it < 4; it++) begin
      L = (it == 0) ? 1 : (it == 3) ? 64 : int'($urandom_range(2, 14));
      mask = (L == 64) ? '1 : ((64'd1 << L) - 64'd1);
      rd = {$urandom, $urandom} & mask;
      rn = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom} & mask;
      do_cfg(L, rd, rn);
      nsym = (it == 3) ? 70 : 3 * L + 3;
      for (int s = 0; s < nsym; s++) begin
        o = int'($urandom_range(1, 42));
        z = (s % 7 == 3) ? int'($urandom_range(55, 75)) : int'($urandom_range(1, 42));
        send_sym(o, z);
      end
      close_sym();
      chk($sformatf("rnd%0d_sym_err", it), 64'(sym_cnt), 64'(exp_sym));
      check_words($sformatf("rnd%0d", it));
    end

    chk("pulse_single_cycle", 64'(viol), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
